// File: rtl/instruction_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instruction_encoder_pkg
// Shared definitions for the RISC-V instruction encoder: opcode constants,
// output-buffer state encodings and the opcode-to-format classifier.
// -----------------------------------------------------------------------------
package instruction_encoder_pkg;

    localparam logic [6:0] OPC_I_LOGIC = 7'h13;
    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_R       = 7'h33;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;

    // Output buffer occupancy states
    localparam logic [1:0] BUF_EMPTY = 2'd0;
    localparam logic [1:0] BUF_ONE   = 2'd1;
    localparam logic [1:0] BUF_TWO   = 2'd2;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_R,
        FMT_U,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_format(input logic [6:0] op);
        fmt_e f;
        case (op)
            OPC_I_LOGIC, OPC_LOAD: f = FMT_I;
            OPC_STORE:             f = FMT_S;
            OPC_BRANCH:            f = FMT_B;
            OPC_R:                 f = FMT_R;
            OPC_LUI, OPC_AUIPC:    f = FMT_U;
            default:               f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/encoder_skid_buffer.sv
// -----------------------------------------------------------------------------
// encoder_skid_buffer
// Two-entry FIFO of {word, addr} with registered ready. The head entry drives
// the outputs directly, so a word pushed into an empty buffer is visible the
// cycle after the push edge.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear_i         synchronous flush (wins over push and pop)
//   push_i          write word_i/addr_i (caller only pushes when ready_o=1)
//   ready_o         buffer not full
//   valid_o         head entry valid
//   ready_i         consumer takes the head entry
//   word_o, addr_o  head entry
// -----------------------------------------------------------------------------
module encoder_skid_buffer
    import instruction_encoder_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [WORD_W-1:0]     word_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_W-1:0]     word_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [1:0]            state_q,     state_d;
    logic [WORD_W-1:0]     head_word_q, head_word_d;
    logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
    logic [WORD_W-1:0]     tail_word_q, tail_word_d;
    logic [ADDR_WIDTH-1:0] tail_addr_q, tail_addr_d;
    logic                  push;
    logic                  pop;

    // Both flags come straight from the state register, never from ready_i
    assign valid_o = (state_q != BUF_EMPTY);
    assign ready_o = (state_q != BUF_TWO);
    assign word_o  = head_word_q;
    assign addr_o  = head_addr_q;

    assign push = push_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        state_d     = state_q;
        head_word_d = head_word_q;
        head_addr_d = head_addr_q;
        tail_word_d = tail_word_q;
        tail_addr_d = tail_addr_q;
        if (clear_i) begin
            state_d     = BUF_EMPTY;
            head_addr_d = BASE;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        head_word_d = word_i;
                        head_addr_d = addr_i;
                        state_d     = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        // head leaves and the new word replaces it
                        head_word_d = word_i;
                        head_addr_d = addr_i;
                    end else if (push) begin
                        tail_word_d = word_i;
                        tail_addr_d = addr_i;
                        state_d     = BUF_TWO;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        head_word_d = tail_word_q;
                        head_addr_d = tail_addr_q;
                        state_d     = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BUF_EMPTY;
            head_word_q <= '0;
            head_addr_q <= BASE;
        end else begin
            state_q     <= state_d;
            head_word_q <= head_word_d;
            head_addr_q <= head_addr_d;
        end
    end

    // The tail is only read in TWO, after it has been written, so it needs no reset
    always_ff @(posedge clk) begin
        tail_word_q <= tail_word_d;
        tail_addr_q <= tail_addr_d;
    end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Packs decoded fields (opcode, registers, funct fields, datapath-form
// immediate) into 32-bit RISC-V words, tags each with a sequential address and
// delivers them through a two-entry valid/ready buffer.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   clear_i              flush buffer, reload address counter with BASE_ADDR
//   valid_i / ready_o    input handshake
//   op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, Immediate_i   fields
//   valid_o / ready_i    output handshake
//   Instruction_bus_o    encoded head word
//   addr_o               address tag of the head word
//   err_o                one-cycle pulse after an input is rejected
// Build option:
//   ENCODER_RANGE_CHECK_EN  reject immediates that would not round-trip
//                           through the immediate generator; otherwise the
//                           excess bits are truncated.
// -----------------------------------------------------------------------------
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [6:0]            op_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [31:0]           Immediate_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [31:0]           Instruction_bus_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  err_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    fmt_e                  fmt;
    logic [31:0]           word;
    logic                  word_ok;
    logic                  range_ok;
    logic                  accept;
    logic                  push;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q,  err_d;

    // Field packing; B-type Imm is already the offset divided by two
    always_comb begin
        fmt  = opcode_format(op_i);
        word = '0;
        case (fmt)
            FMT_I: word = {Immediate_i[11:0], rs1_i, funct3_i, rd_i, op_i};
            FMT_S: word = {Immediate_i[11:5], rs2_i, rs1_i, funct3_i,
                           Immediate_i[4:0], op_i};
            FMT_B: word = {Immediate_i[11], Immediate_i[9:4], rs2_i, rs1_i,
                           funct3_i, Immediate_i[3:0], Immediate_i[10], op_i};
            FMT_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            FMT_U: word = {Immediate_i[19:0], rd_i, op_i};
            default: word = '0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Sign-extended fields need all bits above the field's top bit to match it
    always_comb begin
        case (fmt)
            FMT_I:        range_ok = (&Immediate_i[31:11]) | ~(|Immediate_i[31:11]);
            FMT_S, FMT_B: range_ok = ~(|Immediate_i[31:12]);
            FMT_U:        range_ok = (&Immediate_i[31:19]) | ~(|Immediate_i[31:19]);
            default:      range_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm_hi;
    assign range_ok      = 1'b1;
    assign unused_imm_hi = ^Immediate_i[31:20];
`endif

    assign word_ok = (fmt != FMT_BAD) & range_ok;
    assign accept  = valid_i & ready_o & ~clear_i;
    assign push    = accept & word_ok;

    always_comb begin
        err_d  = accept & ~word_ok;
        addr_d = addr_q;
        if (clear_i) begin
            addr_d = BASE;
        end else if (push) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= BASE;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

    encoder_skid_buffer #(
        .WORD_W    (32),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .clear_i(clear_i),
        .push_i (push),
        .word_i (word),
        .addr_i (addr_q),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .word_o (Instruction_bus_o),
        .addr_o (addr_o)
    );

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields (opcode, registers, funct fields, datapath-form immediate) back into 32-bit RISC-V instruction words. It is the inverse of the core's immediate generator and is used by the program-loader/self-test path to build instruction memory contents in hardware. Each word is tagged with a sequential memory address and delivered through a 2-entry buffered valid/ready output.

## Interface
- ADDR_WIDTH, 6: width of the address tag; the tag counter wraps at 2^ADDR_WIDTH.
- BASE_ADDR, 0: tag value after reset and after `clear_i`.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous flush of the buffer and reload of the address counter.
- valid_i  in  1  input fields valid.
- ready_o  out  1  encoder can accept input.
- op_i  in  7  opcode.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- funct3_i  in  3;  funct7_i  in  7.
- Immediate_i  in  32  immediate in datapath form (see Operation).
- valid_o  out  1  head word valid.
- ready_i  in  1  consumer accepts the head word.
- Instruction_bus_o  out  32  encoded word.
- addr_o  out  ADDR_WIDTH  address tag of the head word.
- err_o  out  1  one-cycle pulse: input rejected.

## Operation
- Formats, by opcode; `Imm` is `Immediate_i`:
  - 0x13, 0x03 (I): {Imm[11:0], rs1, funct3, rd, op}.
  - 0x23 (S): {Imm[11:5], rs2, rs1, funct3, Imm[4:0], op}.
  - 0x63 (B): {Imm[11], Imm[9:4], rs2, rs1, funct3, Imm[3:0], Imm[10], op}. Imm is the branch offset divided by 2.
  - 0x33 (R): {funct7, rs2, rs1, funct3, rd, op}.
  - 0x37, 0x17 (U): {Imm[19:0], rd, op}.
  - Any other opcode: the input is rejected.
- Round-trip property: decoding an encoded word with the core's immediate generator returns Imm.
  - I: Imm[11:0] sign-extended.
  - S and B: Imm[11:0] zero-extended.
  - U: Imm[19:0] sign-extended.
- An input is accepted on `valid_i & ready_o`.
  - A valid accepted input is pushed with the current address, and the counter increments modulo 2^ADDR_WIDTH.
  - A rejected input is consumed without a push. `err_o` pulses and the counter is unchanged.
- Buffer FSM:
  - States: EMPTY, ONE, TWO.
  - Push only: state goes up one. Pop only (`valid_o & ready_i`): state goes down one.
  - Push and pop together in ONE: stays ONE.
  - In TWO no push is possible.
- Output order is strictly FIFO.
- `clear_i` has priority over push and pop. It empties the buffer and sets the counter to BASE_ADDR. An input presented in the same cycle is dropped and `err_o` stays low.
- Reset values: state EMPTY, `valid_o`=0, `ready_o`=1, `Instruction_bus_o`=0, `addr_o`=BASE_ADDR, `err_o`=0.
- Reset mid-operation discards all buffered words.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on `Instruction_bus_o` with `valid_o`=1 after edge N.
- `ready_o` = (state != TWO). It is registered and does not depend on `ready_i` combinationally.
- `err_o` is asserted for exactly the cycle after the rejecting edge.
- Throughput is 1 word/cycle with `ready_i` held high.
- Holding `ready_i` low: ready_o drops after two accepts.
- Head outputs stay stable while `valid_o & !ready_i`.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: an immediate that does not round-trip is rejected (err pulse, no push, counter unchanged). The checks are:
  - I: Imm[31:11] all equal.
  - S and B: Imm[31:12]==0.
  - U: Imm[31:19] all equal.
- Undefined: out-of-range bits are silently truncated and the word is pushed.

## Structure
- Shared definitions file holds:
  - Opcode constants: OPC_I_LOGIC 0x13, OPC_LOAD 0x03, OPC_STORE 0x23, OPC_BRANCH 0x63, OPC_R 0x33, OPC_LUI 0x37, OPC_AUIPC 0x17.
  - Buffer state encodings.
- Packing and range checking are combinational in the top module.
- Sub-module `encoder_skid_buffer`: 2-entry FIFO of {word, addr} carrying the FSM and valid/ready logic.

## Test plan
- addi: op 0x13, rd 5, rs1 1, f3 0, Imm 0xFFFFFFFD -> word 0xFFD08293, addr 0, valid one cycle after accept.
- sw: op 0x23, rs1 3, rs2 2, f3 2, Imm 8 -> 0x0021A423. beq: op 0x63, rs1 1, rs2 2, Imm 0x004 -> 0x00208463. lui: op 0x37, rd 10, Imm 0x12345 -> 0x12345537.
- Backpressure: ready_i=0, three back-to-back inputs -> ready_o low after the second accept. Then ready_i=1 drains the words in order with addr 0,1, and the third is accepted afterwards with addr 2.
- Reject: op 0x7F -> err_o high one cycle, no valid_o, next good word tagged with the unchanged address. With the macro defined, I-type Imm 0x00000800 is rejected the same way.
- Wrap: ADDR_WIDTH=2, five words -> addr 0,1,2,3,0. `clear_i` with the buffer holding two words -> valid_o=0 next cycle, addr back to BASE_ADDR.
- Reset asserted asynchronously with the buffer in TWO -> valid_o=0 and ready_o=1 immediately, addr_o=BASE_ADDR.
